// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Every bit of the read data returned on a timed-out access.
    localparam logic TIMEOUT_FILL = 1'b0;

    localparam int TIMER_W = 16;

    // Terminal count: the timer fires during the WAIT_MAX-th busy cycle.
    function automatic logic [TIMER_W-1:0] timer_limit(input int wait_max);
        return TIMER_W'(wait_max - 1);
    endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Bounded wait counter for the arbiter; expired marks the last allowed busy cycle.
module arb_wait_timer
    import mem_arb_pkg::*;
#(
    parameter int WAIT_MAX = 255
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LIMIT = timer_limit(WAIT_MAX);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + TIMER_W'(1);
        end
    end

    assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF / data) arbiter in front of one variable-latency memory port.
// Build option: MEM_ARB_RR_EN selects round-robin priority on simultaneous requests.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              ireq,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              irdy,
    output logic [DATA_W-1:0] irdata,
    input  logic              dreq,
    input  logic              dwe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dwdata,
    output logic              drdy,
    output logic [DATA_W-1:0] drdata,
    output logic              mreq,
    output logic              mwe,
    output logic [ADDR_W-3:0] maddr,
    output logic [DATA_W-1:0] mwdata,
    input  logic [DATA_W-1:0] mrdata,
    input  logic              mready,
    output logic              err,
    output arb_state_e        dbg_state
);

    // Handshakes: a requester holds req (and its address/data) until its rdy
    // pulse; rdy lasts exactly one cycle. On the memory side mreq is held until
    // a cycle with mready=1, which may be the very first cycle of mreq.

    arb_state_e state_q;
    logic       busy;
    logic       i_elig;
    logic       d_elig;
    logic       can_grant;
    logic       grant_any;
    logic       grant_id;
    logic       done;
    logic       tmr_expired;
    logic       unused_lsbs;

`ifdef MEM_ARB_RR_EN
    logic       rr_q;
`endif

    assign unused_lsbs = ^{iaddr[1:0], daddr[1:0]};
    assign busy        = (state_q == I_BUSY) || (state_q == D_BUSY);
    assign dbg_state   = state_q;

    // A requester whose rdy is showing, or who is being served, still has its
    // old req up and must not be granted again.
    always_comb begin
        i_elig    = ireq && !irdy && (state_q != I_BUSY);
        d_elig    = dreq && !drdy && (state_q != D_BUSY);
        can_grant = (state_q == IDLE) || (busy && mready);
        grant_any = can_grant && (i_elig || d_elig);
        done      = busy && (mready || tmr_expired);
        grant_id  = REQ_I;
        if (i_elig && d_elig) begin
`ifdef MEM_ARB_RR_EN
            grant_id = rr_q;
`else
            grant_id = REQ_D;
`endif
        end else if (d_elig) begin
            grant_id = REQ_D;
        end
    end

    arb_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timer (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (grant_any),
        .enable  (busy),
        .expired (tmr_expired)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            mreq    <= 1'b0;
            mwe     <= 1'b0;
            maddr   <= '0;
            mwdata  <= '0;
            irdy    <= 1'b0;
            drdy    <= 1'b0;
            irdata  <= '0;
            drdata  <= '0;
            err     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_q    <= REQ_D;
`endif
        end else begin
            irdy <= 1'b0;
            drdy <= 1'b0;

            if (done) begin
                if (state_q == I_BUSY) begin
                    irdy   <= 1'b1;
                    irdata <= mready ? mrdata : {DATA_W{TIMEOUT_FILL}};
                end else begin
                    drdy   <= 1'b1;
                    drdata <= (mready && !mwe) ? mrdata : {DATA_W{TIMEOUT_FILL}};
                end
                if (!mready) begin
                    err <= 1'b1;
                end
            end

            if (grant_any) begin
                mreq <= 1'b1;
`ifdef MEM_ARB_RR_EN
                rr_q <= ~grant_id;
`endif
                if (grant_id == REQ_D) begin
                    state_q <= D_BUSY;
                    mwe     <= dwe;
                    maddr   <= daddr[ADDR_W-1:2];
                    mwdata  <= dwdata;
                end else begin
                    state_q <= I_BUSY;
                    mwe     <= 1'b0;
                    maddr   <= iaddr[ADDR_W-1:2];
                    mwdata  <= '0;
                end
            end else if (done || !(busy || state_q == IDLE)) begin
                state_q <= IDLE;
                mreq    <= 1'b0;
                mwe     <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single unified word memory between two requesters: instruction fetch (IF) and data access (MEM stage load/store).
- Sits between the pipeline and a single-port memory that takes a variable number of cycles to answer (req/ready handshake).
- Serialises the two requesters and returns read data to each one.
- Runs a bounded wait timer so that a memory which never answers does not hang the core.

Parameters:
- ADDR_W, 32: byte address width from the requesters; the memory receives word address addr[ADDR_W-1:2].
- DATA_W, 32: data word width.
- WAIT_MAX, 255: maximum number of cycles in a busy state without mready before the access is aborted; legal range 1..65535.

Ports:
- clock, in, 1: the single clock; everything is sampled on posedge.
- resetn, in, 1: asynchronous, active-low reset.
- ireq, in, 1: IF read request; held high with iaddr stable until irdy.
- iaddr, in, ADDR_W: IF byte address.
- irdy, out, 1: one-cycle pulse; the IF access is complete.
- irdata, out, DATA_W: fetched word; valid while irdy=1.
- dreq, in, 1: MEM-stage request; held high with dwe/daddr/dwdata stable until drdy.
- dwe, in, 1: 1 = store, 0 = load.
- daddr, in, ADDR_W: data byte address.
- dwdata, in, DATA_W: store data.
- drdy, out, 1: one-cycle pulse; the data access is complete.
- drdata, out, DATA_W: load data while drdy=1; 0 for stores.
- mreq, out, 1: memory request; held until mready.
- mwe, out, 1: memory write enable; qualified by mreq.
- maddr, out, ADDR_W-2: memory word address.
- mwdata, out, DATA_W: memory write data.
- mrdata, in, DATA_W: memory read data; valid when mready=1.
- mready, in, 1: memory completion; may be high in the first cycle of mreq.
- err, out, 1: sticky timeout flag.

Behaviour:
- Reset values: all outputs 0, state IDLE, wait counter 0, RR pointer = data.
- State IDLE:
  - Sample ireq and dreq.
  - If both are high, the data requester wins (fixed priority).
  - Data winner: go to D_BUSY. IF winner: go to I_BUSY.
  - mreq, mwe, maddr and mwdata are registered and take effect in the next cycle.
- States I_BUSY and D_BUSY:
  - mreq=1; address and data are held constant.
  - The wait counter increments every cycle.
- On mready=1 in a busy state:
  - Next cycle, pulse the winner's rdy.
  - Capture mrdata into the winner's rdata register; drdata is forced to 0 for stores.
  - mreq drops. mreq may re-assert in that same rdy cycle for the other requester (no idle bubble).
- Minimum latency: req seen at edge 0, mreq high in cycle 1, mready=1 in cycle 1, rdy in cycle 2.
- The requester that was just served is masked in its rdy cycle; its still-high req must not be re-granted.
- Back-to-back with both requests pending: D, I, D, I, ... with no idle cycles (this falls out of the masking rule).
- Timeout:
  - When the counter reaches WAIT_MAX with mready=0, drop mreq and pulse the winner's rdy.
  - rdata = 0; set err=1. err stays set until reset.
  - Return to IDLE.
  - The counter clears on every grant.
- mready while in IDLE is ignored.
- Changes to req or address while busy are ignored (a requester protocol violation).
- Reset mid-access:
  - mreq drops asynchronously; no rdy is issued; the access is lost.
  - The memory must tolerate an abandoned request.
- irdy and drdy are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: when both requests are pending, alternate priority using a 1-bit RR pointer. The pointer updates on every grant to point at the requester not just granted.
- Undefined: fixed data-over-IF priority. The pointer logic is absent.

Decomposition:
- Package mem_arb_pkg holds:
  - State encoding: IDLE=2'd0, I_BUSY=2'd1, D_BUSY=2'd2.
  - Requester IDs: REQ_I=1'b0, REQ_D=1'b1.
  - Timeout rdata value: 0.
- One sub-module, arb_wait_timer, holds the WAIT_MAX counter:
  - Inputs: clear, enable.
  - Output: expired.
  - 16-bit counter.

Test Plan:
- Single load: dreq=1, dwe=0, daddr=0x40; memory answers mready in 3 cycles with 0x1234ABCD -> maddr=0x10, drdy pulses once, drdata=0x1234ABCD, err=0.
- Contention: ireq and dreq both rise in the same cycle, zero-wait memory -> first grant goes to D, then to I with no idle cycle between accesses; irdy never coincides with drdy.
- Store: dreq=1, dwe=1, daddr=0x100, dwdata=0xCAFEF00D -> mwe=1, maddr=0x40, mwdata=0xCAFEF00D; drdy with drdata=0.
- Timeout: WAIT_MAX=4, ireq=1, mready held 0 -> mreq drops after 4 busy cycles, irdy pulses with irdata=0, err=1 and stays 1; a following access still completes.
- Reset mid-access: resetn pulled low during D_BUSY -> mreq=0 immediately, no drdy, state IDLE after reset release.
- With MEM_ARB_RR_EN: both requests held continuously for 4 grants -> grant order D, I, D, I. Without the macro: the same order when requesters re-request immediately; D always wins at each simultaneous IDLE decision.
